// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- byte-wide UART transmitter with a valid/ready request interface.
//
// Frame: one start bit (0), eight data bits LSB first, an optional even-parity
// bit, and one stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles. The
// serial output is registered and idles high.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> frame carries an even-parity bit after
//                                   the data bits (11 bits per frame).
//                      undefined -> no parity bit; DATA goes straight to STOP
//                                   (10 bits per frame).
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit, 1..65535 (default 1).
//
// Ports:
//   clk       rising-edge clock for all state.
//   rst       asynchronous, active-high reset.
//   tx_data   byte to send; sampled only on the handshake edge.
//   tx_valid  requester has a byte on tx_data.
//   tx_ready  transmitter can accept a byte this cycle (high only in IDLE).
//   tx_out    serial line, idles high.
//   tx_busy   a frame is in progress (state is not IDLE).
//   tx_done   one-cycle pulse in the cycle after the last stop-bit cycle.
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       tx_done
);

    // Last count value of a bit period; the baud counter wraps to 0 here.
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t      state_q, state_n;
    logic [15:0] baud_q,  baud_n;
    logic [2:0]  bit_q,   bit_n;
    logic [7:0]  data_q,  data_n;
    logic        tx_out_n;
    logic        done_n;
    logic        bit_end;

    assign bit_end  = (baud_q == BAUD_LAST);
    assign tx_ready = (state_q == IDLE);
    assign tx_busy  = (state_q != IDLE);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case statements can leave one unassigned and
        // infer a latch.
        state_n  = state_q;
        baud_n   = baud_q;
        bit_n    = bit_q;
        data_n   = data_q;
        done_n   = 1'b0;
        tx_out_n = 1'b1;

        // The baud counter only runs inside a frame and restarts at every
        // bit boundary, so each state sees a fresh count from 0.
        if (state_q != IDLE) begin
            baud_n = bit_end ? 16'd0 : baud_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_n = START;
                    data_n  = tx_data;
                    baud_n  = 16'd0;
                    bit_n   = 3'd0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    // bit_n wraps 7 -> 0 on the last data bit, which leaves it
                    // cleared for the next frame.
                    bit_n = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // tx_out is registered, so it is computed from the state being
        // entered; the line then changes on the same edge as the state.
        unique case (state_n)
            START:   tx_out_n = 1'b0;
            DATA:    tx_out_n = data_n[bit_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_n = ^data_n;
`endif
            default: tx_out_n = 1'b1;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the latched byte is cleared on reset as well as the
            // control state, so an aborted frame leaves nothing behind.
            state_q <= IDLE;
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            data_q  <= 8'd0;
            tx_out  <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state_q <= state_n;
            baud_q  <= baud_n;
            bit_q   <= bit_n;
            data_q  <= data_n;
            tx_out  <= tx_out_n;
            tx_done <= done_n;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx -- self-checking bench for uart_tx.
//
// Three transmitters with CLKS_PER_BIT = 1, 4 and 2 share clock and reset.
// Expected frames come from directed bytes and hand-written bit patterns;
// a small line receiver on the CLKS_PER_BIT = 1 instance decodes its frames
// for the loopback checks. Works with UART_TX_PARITY_EN defined or not.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data_a  [3];
    logic       tx_valid_a [3];
    logic       tx_ready_a [3];
    logic       tx_out_a   [3];
    logic       tx_busy_a  [3];
    logic       tx_done_a  [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(1)) u_cpb1 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_a[0]), .tx_valid(tx_valid_a[0]), .tx_ready(tx_ready_a[0]),
        .tx_out(tx_out_a[0]), .tx_busy(tx_busy_a[0]), .tx_done(tx_done_a[0])
    );

    uart_tx #(.CLKS_PER_BIT(4)) u_cpb4 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_a[1]), .tx_valid(tx_valid_a[1]), .tx_ready(tx_ready_a[1]),
        .tx_out(tx_out_a[1]), .tx_busy(tx_busy_a[1]), .tx_done(tx_done_a[1])
    );

    uart_tx #(.CLKS_PER_BIT(2)) u_cpb2 (
        .clk(clk), .rst(rst),
        .tx_data(tx_data_a[2]), .tx_valid(tx_valid_a[2]), .tx_ready(tx_ready_a[2]),
        .tx_out(tx_out_a[2]), .tx_busy(tx_busy_a[2]), .tx_done(tx_done_a[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as bit k = k-th bit on the line: start, data LSB first,
    // optional even parity, stop.
    function automatic logic [11:0] frame_bits(input logic [7:0] d);
        logic [11:0] f;
        f    = '0;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]  = ^d;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    // ------------------------------------------------------------------------
    // Line receiver on the CLKS_PER_BIT = 1 instance.
    // ------------------------------------------------------------------------
    logic [11:0] rx_shift  = '0;
    int          rx_pos    = 0;
    logic        rx_active = 1'b0;
    logic [7:0]  rx_byte   = '0;
    logic        rx_ok     = 1'b0;
    int          rx_count  = 0;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_active <= 1'b0;
            rx_pos    <= 0;
        end else if (!rx_active) begin
            if (tx_out_a[0] == 1'b0) begin
                rx_active <= 1'b1;
                rx_pos    <= 1;
                rx_shift  <= '0;
            end
        end else if (rx_pos == FRAME_BITS - 1) begin
            rx_byte   <= rx_shift[8:1];
`ifdef UART_TX_PARITY_EN
            rx_ok     <= (tx_out_a[0] == 1'b1) && (rx_shift[9] == ^rx_shift[8:1]);
`else
            rx_ok     <= (tx_out_a[0] == 1'b1);
`endif
            rx_count  <= rx_count + 1;
            rx_active <= 1'b0;
        end else begin
            rx_shift[rx_pos] <= tx_out_a[0];
            rx_pos           <= rx_pos + 1;
        end
    end

    // Send one byte on instance inst (called at a falling edge while idle).
    // Checks the line every cycle, the done pulse and the return to idle;
    // returns the first-cycle sample of each bit and the busy cycle count.
    task automatic send_frame(input int inst, input int cpb, input logic [7:0] data,
                              input string tag, output logic [11:0] bits,
                              output int busy_cycles);
        logic [11:0] exp;
        int          len;
        exp = frame_bits(data);
        len = FRAME_BITS * cpb;
        bits = '0;
        busy_cycles = 0;
        check({tag, ".ready_before"}, 32'(tx_ready_a[inst]), 32'd1);
        tx_data_a[inst]  = data;
        tx_valid_a[inst] = 1'b1;
        for (int n = 0; n < len; n++) begin
            @(negedge clk);
            if (n == 0) begin
                tx_valid_a[inst] = 1'b0;
                tx_data_a[inst]  = ~data;
                check({tag, ".ready_in_frame"}, 32'(tx_ready_a[inst]), 32'd0);
            end
            check($sformatf("%s.line[%0d]", tag, n), 32'(tx_out_a[inst]), 32'(exp[n / cpb]));
            check($sformatf("%s.done[%0d]", tag, n), 32'(tx_done_a[inst]), 32'd0);
            if (n % cpb == 0) bits[n / cpb] = tx_out_a[inst];
            if (tx_busy_a[inst]) busy_cycles++;
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, 32'(tx_done_a[inst]), 32'd1);
        check({tag, ".idle_line"},  32'(tx_out_a[inst]),  32'd1);
        check({tag, ".idle_busy"},  32'(tx_busy_a[inst]), 32'd0);
        check({tag, ".idle_ready"}, 32'(tx_ready_a[inst]), 32'd1);
        @(negedge clk);
        check({tag, ".done_low"}, 32'(tx_done_a[inst]), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [11:0] bits;
        int          busy;
        int          rx_before;
        logic [11:0] f1, f2;
        int          len;
        logic        exp_line;
        logic        exp_done;

        for (int i = 0; i < 3; i++) begin
            tx_data_a[i]  = 8'h00;
            tx_valid_a[i] = 1'b0;
        end

        // Reset state while rst is held.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset[%0d].tx_out", i),   32'(tx_out_a[i]),   32'd1);
            check($sformatf("reset[%0d].tx_ready", i), 32'(tx_ready_a[i]), 32'd1);
            check($sformatf("reset[%0d].tx_busy", i),  32'(tx_busy_a[i]),  32'd0);
            check($sformatf("reset[%0d].tx_done", i),  32'(tx_done_a[i]),  32'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 0xA5 at one clock per bit: parity bit is 0.
        rx_before = rx_count;
        send_frame(0, 1, 8'hA5, "a5_cpb1", bits, busy);
`ifdef UART_TX_PARITY_EN
        check("a5_cpb1.pattern", 32'(bits), 32'b010101001010);
        check("a5_cpb1.parity",  32'(bits[9]), 32'd0);
        check("a5_cpb1.busy",    32'(busy), 32'd11);
`else
        check("a5_cpb1.pattern", 32'(bits), 32'b001101001010);
        check("a5_cpb1.busy",    32'(busy), 32'd10);
`endif
        check("a5_cpb1.rx_count", 32'(rx_count - rx_before), 32'd1);
        check("a5_cpb1.rx_byte",  32'(rx_byte), 32'hA5);

        // 0x07 at four clocks per bit: parity bit is 1.
        send_frame(1, 4, 8'h07, "07_cpb4", bits, busy);
`ifdef UART_TX_PARITY_EN
        check("07_cpb4.pattern", 32'(bits), 32'b011000001110);
        check("07_cpb4.parity",  32'(bits[9]), 32'd1);
        check("07_cpb4.busy",    32'(busy), 32'd44);
`else
        check("07_cpb4.pattern", 32'(bits), 32'b001000001110);
        check("07_cpb4.busy",    32'(busy), 32'd40);
`endif

        // 0x80 at two clocks per bit: only the last data bit is 1.
        send_frame(2, 2, 8'h80, "80_cpb2", bits, busy);
`ifdef UART_TX_PARITY_EN
        check("80_cpb2.pattern", 32'(bits), 32'b011100000000);
        check("80_cpb2.busy",    32'(busy), 32'd22);
`else
        check("80_cpb2.pattern", 32'(bits), 32'b001100000000);
        check("80_cpb2.busy",    32'(busy), 32'd20);
`endif

        // Back-to-back 0x55 then 0xAA with tx_valid held high; tx_data
        // changes during each frame must not reach the line.
        rx_before = rx_count;
        f1  = frame_bits(8'h55);
        f2  = frame_bits(8'hAA);
        len = FRAME_BITS;
        tx_data_a[0]  = 8'h55;
        tx_valid_a[0] = 1'b1;
        for (int n = 1; n <= 2 * len + 2; n++) begin
            @(negedge clk);
            if (n == 1) tx_data_a[0] = 8'hAA;
            if (n <= len)              exp_line = f1[n - 1];
            else if (n == len + 1)     exp_line = 1'b1;
            else if (n <= 2 * len + 1) exp_line = f2[n - len - 2];
            else                       exp_line = 1'b1;
            exp_done = (n == len + 1) || (n == 2 * len + 2);
            check($sformatf("b2b.line[%0d]", n), 32'(tx_out_a[0]),  32'(exp_line));
            check($sformatf("b2b.done[%0d]", n), 32'(tx_done_a[0]), 32'(exp_done));
            check($sformatf("b2b.busy[%0d]", n), 32'(tx_busy_a[0]), 32'(!exp_done));
            if (n == len + 2) begin
                tx_valid_a[0] = 1'b0;
                tx_data_a[0]  = 8'h00;
            end
        end
        check("b2b.rx_count", 32'(rx_count - rx_before), 32'd2);
        check("b2b.rx_last",  32'(rx_byte), 32'hAA);
        @(negedge clk);

        // Reset during data bit 3 of 0xF0 aborts the frame at once.
        rx_before = rx_count;
        tx_data_a[0]  = 8'hF0;
        tx_valid_a[0] = 1'b1;
        @(negedge clk);
        tx_valid_a[0] = 1'b0;
        check("abort.start", 32'(tx_out_a[0]), 32'd0);
        repeat (4) @(negedge clk);
        check("abort.bit3", 32'(tx_out_a[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("abort.tx_out",   32'(tx_out_a[0]),   32'd1);
        check("abort.tx_ready", 32'(tx_ready_a[0]), 32'd1);
        check("abort.tx_busy",  32'(tx_busy_a[0]),  32'd0);
        check("abort.tx_done",  32'(tx_done_a[0]),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            check($sformatf("abort.quiet_done[%0d]", n), 32'(tx_done_a[0]), 32'd0);
            check($sformatf("abort.quiet_line[%0d]", n), 32'(tx_out_a[0]),  32'd1);
        end
        check("abort.rx_none", 32'(rx_count - rx_before), 32'd0);

        // Loopback: fresh frames after the abort decode unchanged and valid.
        send_frame(0, 1, 8'h3C, "loop_3c", bits, busy);
        check("loop_3c.rx_byte", 32'(rx_byte), 32'h3C);
        check("loop_3c.rx_ok",   32'(rx_ok),   32'd1);
        send_frame(0, 1, 8'h00, "loop_00", bits, busy);
        check("loop_00.rx_byte", 32'(rx_byte), 32'h00);
        check("loop_00.rx_ok",   32'(rx_ok),   32'd1);
        send_frame(0, 1, 8'hFF, "loop_ff", bits, busy);
        check("loop_ff.rx_byte", 32'(rx_byte), 32'hFF);
        check("loop_ff.rx_ok",   32'(rx_ok),   32'd1);
        check("loop.rx_count", 32'(rx_count - rx_before), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
